// File: rtl/sort_pkg.sv
// Shared types and constants for the bubble-sort unit and its result checker.
package sort_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StFirst,
        StScan,
        StDone
    } sort_chk_state_e;

    localparam int unsigned AwDefault = 8;
    localparam int unsigned DwDefault = 32;

    localparam logic [15:0] CYC_MAX = 16'hFFFF;

endpackage

// File: rtl/sort_result_checker.sv
// Scans the sorted array (M[0] = n, M[1..n] = elements) and reports order, first violation and
// scan length. The element checksum is built only when SORT_CHECK_CKSUM_EN is defined.
module sort_result_checker
    import sort_pkg::*;
#(
    parameter int unsigned AW = AwDefault,
    parameter int unsigned DW = DwDefault
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [AW-1:0] err_idx,
    output logic [DW-1:0] checksum,
    output logic [15:0]   rd_cycles
);

    localparam logic [AW-1:0] NMax = '1;

    sort_chk_state_e state_q, state_d;
    logic [AW-1:0]   n_q, n_d;
    logic [AW-1:0]   j_q, j_d;
    logic [DW-1:0]   prev_q, prev_d;
    logic            pass_q, pass_d;
    logic [AW-1:0]   err_q, err_d;
    logic [15:0]     cyc_q, cyc_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [AW-1:0]   n_len;
    logic [15:0]     cyc_inc;
    logic            viol;
    logic            restart;

    // Lengths beyond the address space are clamped to the last addressable word.
    assign n_len   = (mem_rdata > DW'(NMax)) ? NMax : mem_rdata[AW-1:0];
    assign cyc_inc = (cyc_q == CYC_MAX) ? cyc_q : cyc_q + 16'd1;
    assign viol    = prev_q > mem_rdata;
    assign restart = start && ((state_q == StIdle) || (state_q == StDone));

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        j_d      = j_q;
        prev_d   = prev_q;
        pass_d   = pass_q;
        err_d    = err_q;
        cyc_d    = cyc_q;
        mem_addr = '0;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    pass_d  = 1'b0;
                    err_d   = '0;
                    cyc_d   = '0;
                    state_d = StLen;
                end
            end
            StLen: begin
                n_d   = n_len;
                cyc_d = cyc_inc;
                if (n_len == '0) begin
                    pass_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    state_d = StFirst;
                end
            end
            StFirst: begin
                mem_addr = AW'(1);
                prev_d   = mem_rdata;
                j_d      = AW'(2);
                cyc_d    = cyc_inc;
                if (n_q == AW'(1)) begin
                    pass_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    state_d = StScan;
                end
            end
            StScan: begin
                mem_addr = j_q;
                prev_d   = mem_rdata;
                cyc_d    = cyc_inc;
                // err_idx is never 0 once set (j starts at 2), so it doubles as the violation flag.
                if (viol && (err_q == '0)) begin
                    err_d = j_q;
                end
                if (j_q == n_q) begin
                    pass_d  = (err_q == '0) && !viol;
                    state_d = StDone;
                end else begin
                    j_d = j_q + AW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StLen) || (state_d == StFirst) || (state_d == StScan);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            n_q     <= '0;
            j_q     <= '0;
            prev_q  <= '0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            cyc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            j_q     <= j_d;
            prev_q  <= prev_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            cyc_q   <= cyc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef SORT_CHECK_CKSUM_EN
    logic [DW-1:0] cks_q, cks_d;

    always_comb begin
        cks_d = cks_q;
        if (restart) begin
            cks_d = '0;
        end else if (state_q == StFirst) begin
            cks_d = mem_rdata;
        end else if (state_q == StScan) begin
            cks_d = cks_q + mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cks_q <= '0;
        end else begin
            cks_q <= cks_d;
        end
    end

    assign checksum = cks_q;
`else
    logic unused_restart;
    assign unused_restart = restart;
    assign checksum       = '0;
`endif

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_idx   = err_q;
    assign rd_cycles = cyc_q;

endmodule

// File: tb/tb_sort_result_checker.sv
// Directed bench for sort_result_checker; expected checksums follow SORT_CHECK_CKSUM_EN.
module tb_sort_result_checker;
    import sort_pkg::*;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          done;
    logic          pass;
    logic [AW-1:0] err_idx;
    logic [DW-1:0] checksum;
    logic [15:0]   rd_cycles;

    logic [DW-1:0] mem [256];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    sort_result_checker #(
        .AW(AW),
        .DW(DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mem_addr (mem_addr),
        .mem_rdata(mem_rdata),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_idx  (err_idx),
        .checksum (checksum),
        .rd_cycles(rd_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_cks(input logic [31:0] sum);
`ifdef SORT_CHECK_CKSUM_EN
        return sum;
`else
        return (sum & 32'h0);
`endif
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = '0;
    endtask

    // Returns at the negedge after the sampling edge; one cycle (the start cycle) has elapsed.
    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Counts cycles from the start cycle until done is seen, bounded.
    task automatic wait_done(input int cnt_in, output int cnt);
        cnt = cnt_in;
        while (!done && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic check_result(input string tag, input int cnt, input int exp_cnt,
                                input logic exp_pass, input logic [31:0] exp_err,
                                input logic [31:0] exp_sum, input logic [31:0] exp_rdc);
        chk({tag, "_latency"}, cnt, exp_cnt);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_pass"}, {31'd0, pass}, {31'd0, exp_pass});
        chk({tag, "_err_idx"}, {24'd0, err_idx}, exp_err);
        chk({tag, "_checksum"}, checksum, exp_cks(exp_sum));
        chk({tag, "_rd_cycles"}, {16'd0, rd_cycles}, exp_rdc);
        chk({tag, "_addr_done"}, {24'd0, mem_addr}, 32'd0);
    endtask

    task automatic run_case(input string tag, input int exp_cnt, input logic exp_pass,
                            input logic [31:0] exp_err, input logic [31:0] exp_sum,
                            input logic [31:0] exp_rdc);
        int cnt;
        pulse_start();
        wait_done(1, cnt);
        check_result(tag, cnt, exp_cnt, exp_pass, exp_err, exp_sum, exp_rdc);
    endtask

    initial begin
        int cnt;
        rst   = 1'b1;
        start = 1'b0;
        clear_mem();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_pass", {31'd0, pass}, 32'd0);
        chk("reset_err_idx", {24'd0, err_idx}, 32'd0);
        chk("reset_checksum", checksum, 32'd0);
        chk("reset_rd_cycles", {16'd0, rd_cycles}, 32'd0);
        chk("reset_addr", {24'd0, mem_addr}, 32'd0);

        // Sorted with equal neighbours; also probe addresses during LEN/FIRST/SCAN.
        mem[0] = 4; mem[1] = 3; mem[2] = 7; mem[3] = 7; mem[4] = 9;
        pulse_start();
        chk("c1_busy_len", {31'd0, busy}, 32'd1);
        chk("c1_addr_len", {24'd0, mem_addr}, 32'd0);
        @(negedge clk);
        chk("c1_addr_first", {24'd0, mem_addr}, 32'd1);
        @(negedge clk);
        chk("c1_addr_scan2", {24'd0, mem_addr}, 32'd2);
        chk("c1_done_mid", {31'd0, done}, 32'd0);
        wait_done(3, cnt);
        check_result("c1", cnt, 6, 1'b1, 0, 26, 5);

        // Restart from DONE with a second start issued mid-scan; it must be ignored.
        pulse_start();
        @(negedge clk);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("c1b_addr_scan3", {24'd0, mem_addr}, 32'd3);
        wait_done(4, cnt);
        check_result("c1b", cnt, 6, 1'b1, 0, 26, 5);

        // Two violations; only the first is reported, scan runs to n.
        clear_mem();
        mem[0] = 5; mem[1] = 1; mem[2] = 8; mem[3] = 2; mem[4] = 9; mem[5] = 0;
        run_case("c2", 7, 1'b0, 3, 20, 6);

        // n = 0.
        clear_mem();
        run_case("n0", 2, 1'b1, 0, 0, 1);

        // n = 1 with an all-ones element.
        mem[0] = 1; mem[1] = 32'hFFFF_FFFF;
        run_case("n1", 3, 1'b1, 0, 32'hFFFF_FFFF, 2);

        // Unsigned compare over full width: 0x80000000 > 0x7FFFFFFF is a violation.
        clear_mem();
        mem[0] = 2; mem[1] = 32'h8000_0000; mem[2] = 32'h7FFF_FFFF;
        run_case("uns", 4, 1'b0, 2, 32'hFFFF_FFFF, 3);

        // Oversized length clamps to 255; a violation at the very last index.
        mem[0] = 300;
        for (int i = 1; i < 255; i++) mem[i] = i;
        mem[255] = 0;
        run_case("clamp", 257, 1'b0, 255, 32385, 256);

        // Reset mid-scan at j = 3, then re-check.
        clear_mem();
        mem[0] = 5; mem[1] = 1; mem[2] = 8; mem[3] = 2; mem[4] = 9; mem[5] = 0;
        pulse_start();
        repeat (3) @(negedge clk);
        chk("rst_addr_scan3", {24'd0, mem_addr}, 32'd3);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_pass", {31'd0, pass}, 32'd0);
        chk("midrst_err_idx", {24'd0, err_idx}, 32'd0);
        chk("midrst_checksum", checksum, 32'd0);
        chk("midrst_rd_cycles", {16'd0, rd_cycles}, 32'd0);
        chk("midrst_addr", {24'd0, mem_addr}, 32'd0);
        repeat (2) @(negedge clk);
        chk("midrst_idle_busy", {31'd0, busy}, 32'd0);
        run_case("c2r", 7, 1'b0, 3, 20, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
